usb_rx_txn_ctrl: RTL and testbench

USB_RX_TXN_CTRL -- requirements
Module: usb_rx_txn_ctrl

---
 rtl/usb_rx_txn_ctrl.sv | 153 +++++++++++++++
 tb/tb_usb_rx_txn_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_txn_ctrl.sv
// USB OUT-transaction receive controller: data toggle, ACK/NAK handshake.
// Optional WAIT_DATA timeout enabled by defining USB_RX_TIMEOUT_EN.
module usb_rx_txn_ctrl (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] rx_pid,
  input  logic       rx_pid_valid,
  input  logic       rx_done,
  input  logic       rx_error,
  input  logic       host_ack,
  input  logic       clear_toggle,
  input  logic       tx_done,
  output logic       tx_start,
  output logic [3:0] tx_pid,
  output logic       clear_buffer,
  output logic       rx_data_ready,
  output logic       timeout_err
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    WAIT_DONE,
    RESP,
    WAIT_TX,
    FLUSH
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       toggle;
  logic       toggle_match;
  logic       match_nxt;
  logic       rdy_set;
  logic       flip;
  logic [3:0] resp_pid;
  logic [3:0] pid_q;
  logic       is_data;
  logic       tmo;

  assign is_data = (rx_pid == PID_DATA0) || (rx_pid == PID_DATA1);

`ifdef USB_RX_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Held at zero outside WAIT_DATA, so it starts from 0 on every entry.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      tmo_cnt <= 8'd0;
    else if (state != WAIT_DATA)
      tmo_cnt <= 8'd0;
    else
      tmo_cnt <= tmo_cnt + 8'd1;
  end

  assign tmo = (state == WAIT_DATA) && (tmo_cnt == 8'hff);
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    match_nxt    = toggle_match;
    tx_start     = 1'b0;
    clear_buffer = 1'b0;
    timeout_err  = 1'b0;
    rdy_set      = 1'b0;
    flip         = 1'b0;
    resp_pid     = PID_ACK;
    unique case (state)
      IDLE: begin
        if (rx_pid_valid && rx_pid == PID_OUT)
          state_nxt = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (rx_pid_valid) begin
          if (is_data) begin
            state_nxt = WAIT_DONE;
            match_nxt = (rx_pid[3] == toggle);
          end else begin
            state_nxt = FLUSH;
          end
        end else if (rx_error) begin
          state_nxt = FLUSH;
        end else if (tmo) begin
          state_nxt   = IDLE;
          timeout_err = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (rx_error)
          state_nxt = FLUSH;
        else if (rx_done)
          state_nxt = RESP;
      end
      RESP: begin
        tx_start  = 1'b1;
        state_nxt = WAIT_TX;
        if (rx_data_ready) begin
          resp_pid     = PID_NAK;
          clear_buffer = 1'b1;
        end else if (!toggle_match) begin
          clear_buffer = 1'b1;
        end else begin
          rdy_set = 1'b1;
          flip    = 1'b1;
        end
      end
      WAIT_TX: begin
        if (tx_done)
          state_nxt = IDLE;
      end
      FLUSH: begin
        clear_buffer = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      toggle        <= 1'b0;
      toggle_match  <= 1'b0;
      rx_data_ready <= 1'b0;
      pid_q         <= 4'b0000;
    end else begin
      state        <= state_nxt;
      toggle_match <= match_nxt;
      if (rdy_set)
        rx_data_ready <= 1'b1;
      else if (host_ack)
        rx_data_ready <= 1'b0;
      if (clear_toggle)
        toggle <= 1'b0;
      else if (flip)
        toggle <= ~toggle;
      if (state == RESP)
        pid_q <= resp_pid;
    end
  end

  // Present the PID in the tx_start cycle, then hold it through WAIT_TX.
  assign tx_pid = (state == RESP) ? resp_pid : pid_q;

endmodule

// File: tb/tb_usb_rx_txn_ctrl.sv
// Directed self-checking bench for usb_rx_txn_ctrl.
module tb_usb_rx_txn_ctrl;

  localparam logic [3:0] OUT_P = 4'b0001;
  localparam logic [3:0] D0    = 4'b0011;
  localparam logic [3:0] D1    = 4'b1011;
  localparam logic [3:0] ACK_P = 4'b0010;
  localparam logic [3:0] NAK_P = 4'b1010;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [3:0] rx_pid;
  logic       rx_pid_valid;
  logic       rx_done;
  logic       rx_error;
  logic       host_ack;
  logic       clear_toggle;
  logic       tx_done;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic       clear_buffer;
  logic       rx_data_ready;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;
  logic seen;

  usb_rx_txn_ctrl dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rx_pid       (rx_pid),
    .rx_pid_valid (rx_pid_valid),
    .rx_done      (rx_done),
    .rx_error     (rx_error),
    .host_ack     (host_ack),
    .clear_toggle (clear_toggle),
    .tx_done      (tx_done),
    .tx_start     (tx_start),
    .tx_pid       (tx_pid),
    .clear_buffer (clear_buffer),
    .rx_data_ready(rx_data_ready),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pid(input logic [3:0] p);
    rx_pid       = p;
    rx_pid_valid = 1'b1;
    step();
    rx_pid_valid = 1'b0;
    rx_pid       = 4'b0000;
  endtask

  task automatic done_pulse();
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  task automatic err_pulse();
    rx_error = 1'b1;
    step();
    rx_error = 1'b0;
  endtask

  task automatic ack_pulse();
    host_ack = 1'b1;
    step();
    host_ack = 1'b0;
  endtask

  // OUT + DATA + rx_done; returns sampled in the RESP cycle.
  task automatic txn(input logic [3:0] p);
    send_pid(OUT_P);
    send_pid(p);
    done_pulse();
  endtask

  task automatic finish_tx();
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic resp(input string tag, input logic [3:0] pid,
                      input logic cb);
    chk({tag, "_start"}, {3'b0, tx_start}, 4'h1);
    chk({tag, "_pid"}, tx_pid, pid);
    chk({tag, "_cb"}, {3'b0, clear_buffer}, {3'b0, cb});
  endtask

  initial begin
    n_rst = 1'b0; rx_pid = 4'b0; rx_pid_valid = 1'b0; rx_done = 1'b0;
    rx_error = 1'b0; host_ack = 1'b0; clear_toggle = 1'b0; tx_done = 1'b0;
    #12;
    chk("rst_start", {3'b0, tx_start}, 4'h0);
    chk("rst_pid", tx_pid, 4'h0);
    chk("rst_cb", {3'b0, clear_buffer}, 4'h0);
    chk("rst_rdy", {3'b0, rx_data_ready}, 4'h0);
    chk("rst_tmo", {3'b0, timeout_err}, 4'h0);
    n_rst = 1'b1;
    step();

    // Fresh DATA0 with toggle 0: ACK one cycle after rx_done
    txn(D0);
    resp("a", ACK_P, 1'b0);
    chk("a_rdy_pre", {3'b0, rx_data_ready}, 4'h0);
    step();
    chk("a_wtx_start", {3'b0, tx_start}, 4'h0);
    chk("a_wtx_pid", tx_pid, ACK_P);
    chk("a_rdy", {3'b0, rx_data_ready}, 4'h1);
    step();
    chk("a_hold_pid", tx_pid, ACK_P);
    tx_done = 1'b1; step(); tx_done = 1'b0;
    ack_pulse();
    chk("a_hack", {3'b0, rx_data_ready}, 4'h0);

    // Repeated DATA0, toggle now 1: duplicate
    txn(D0);
    resp("b", ACK_P, 1'b1);
    finish_tx();
    chk("b_rdy", {3'b0, rx_data_ready}, 4'h0);

    // DATA1 matches toggle 1
    txn(D1);
    resp("c", ACK_P, 1'b0);
    finish_tx();
    chk("c_rdy", {3'b0, rx_data_ready}, 4'h1);

    // Buffer still full: NAK, toggle stays 0
    txn(D1);
    resp("d", NAK_P, 1'b1);
    finish_tx();
    chk("d_rdy", {3'b0, rx_data_ready}, 4'h1);
    ack_pulse();

    // DATA0 matches toggle 0; host_ack and clear_toggle during RESP
    txn(D0);
    resp("e", ACK_P, 1'b0);
    host_ack = 1'b1; clear_toggle = 1'b1;
    step();
    host_ack = 1'b0; clear_toggle = 1'b0;
    chk("e_set_wins", {3'b0, rx_data_ready}, 4'h1);
    tx_done = 1'b1; step(); tx_done = 1'b0;
    ack_pulse();

    // clear_toggle won: DATA0 is fresh again
    txn(D0);
    resp("f", ACK_P, 1'b0);
    finish_tx();
    ack_pulse();

    // rx_error after DATA0 -> FLUSH then IDLE; toggle stays 1
    send_pid(OUT_P);
    send_pid(D0);
    err_pulse();
    chk("g_flush_cb", {3'b0, clear_buffer}, 4'h1);
    chk("g_flush_start", {3'b0, tx_start}, 4'h0);
    step();
    chk("g_idle_cb", {3'b0, clear_buffer}, 4'h0);
    send_pid(D0);
    done_pulse();
    chk("g_ignore_start", {3'b0, tx_start}, 4'h0);

    // Non-DATA PID in WAIT_DATA -> FLUSH
    send_pid(OUT_P);
    send_pid(ACK_P);
    chk("h_flush_cb", {3'b0, clear_buffer}, 4'h1);
    chk("h_flush_start", {3'b0, tx_start}, 4'h0);
    step();

    // rx_error beats rx_done
    send_pid(OUT_P);
    send_pid(D1);
    rx_done = 1'b1; rx_error = 1'b1;
    step();
    rx_done = 1'b0; rx_error = 1'b0;
    chk("i_flush_cb", {3'b0, clear_buffer}, 4'h1);
    chk("i_flush_start", {3'b0, tx_start}, 4'h0);
    step();

    seen = 1'b0;
    send_pid(OUT_P);
`ifdef USB_RX_TIMEOUT_EN
    for (int i = 0; i < 254; i++) begin
      seen |= timeout_err;
      step();
    end
    seen |= timeout_err;
    chk("t_early", {3'b0, seen}, 4'h0);
    step();
    chk("t_pulse", {3'b0, timeout_err}, 4'h1);
    step();
    chk("t_once", {3'b0, timeout_err}, 4'h0);
    send_pid(D1);
    done_pulse();
    chk("t_idle_start", {3'b0, tx_start}, 4'h0);
    send_pid(OUT_P);
`else
    for (int i = 0; i < 300; i++) begin
      seen |= timeout_err;
      step();
    end
    chk("t_none", {3'b0, seen}, 4'h0);
`endif
    // Toggle is 1: DATA1 accepted
    send_pid(D1);
    done_pulse();
    resp("j", ACK_P, 1'b0);
    finish_tx();
    ack_pulse();

    // Reset while in WAIT_TX (toggle 0, DATA1 is a duplicate)
    txn(D1);
    resp("k", ACK_P, 1'b1);
    step();
    chk("k_wtx_pid", tx_pid, ACK_P);
    #2 n_rst = 1'b0;
    #1;
    chk("k_rst_start", {3'b0, tx_start}, 4'h0);
    chk("k_rst_pid", tx_pid, 4'h0);
    chk("k_rst_cb", {3'b0, clear_buffer}, 4'h0);
    chk("k_rst_rdy", {3'b0, rx_data_ready}, 4'h0);
    chk("k_rst_tmo", {3'b0, timeout_err}, 4'h0);
    step();
    n_rst = 1'b1;
    step();
    txn(D0);
    resp("l", ACK_P, 1'b0);
    finish_tx();
    chk("l_rdy", {3'b0, rx_data_ready}, 4'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
